// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for the port arbiter; slave = arbiter side.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              addr_sel;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              if_stall;
  logic              dm_stall;

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, addr_sel, if_valid, if_rdata,
           dm_valid, dm_rdata, if_stall, dm_stall
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, addr_sel, if_valid, if_rdata,
           dm_valid, dm_rdata, if_stall, dm_stall
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 16-bit 2:1 address mux (Bits16_Mux2_1): a when sel = 0, b when sel = 1.
module mem_port_arbiter_mux
  import mem_port_arbiter_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  input  logic              sel,
  output logic [ADDR_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              addr_sel;

  logic              starved_c;
  logic              grant_c;
  logic              owner_c;
  logic              done_c;
  logic [ADDR_W-1:0] addr_mux_c;

  // DM normally wins a tie; IF wins once DM has taken STARVE_LIMIT grants in a row.
  assign starved_c = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_c   = (state == ST_IDLE) & (bus.if_req | bus.dm_req);
  assign owner_c   = (bus.dm_req & ~(bus.if_req & starved_c)) ? OWNER_DM : OWNER_IF;

  mem_port_arbiter_mux u_addr_mux (
    .a   (bus.if_addr),
    .b   (bus.dm_addr),
    .sel (owner_c),
    .y   (addr_mux_c)
  );

  // Transaction FSM: grant and latch in IDLE, strobe in ISSUE, hold until mem_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_sel  <= OWNER_IF;
    end else begin
      mem_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_c) begin
            state     <= ST_ISSUE;
            mem_en    <= 1'b1;
            addr_sel  <= owner_c;
            mem_addr  <= addr_mux_c;
            mem_wdata <= bus.dm_wdata;
            mem_wr    <= bus.dm_wr & (owner_c == OWNER_DM);
          end
        end
        ST_ISSUE: state <= bus.mem_done ? ST_IDLE : ST_WAIT;
        ST_WAIT:  if (bus.mem_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Counts DM grants taken while IF is waiting; any IF grant or idle IF clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || (grant_c && owner_c == OWNER_IF)) begin
      starve_cnt <= '0;
    end else if (grant_c && !starved_c) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Completion only counts while a transaction is owned; stray mem_done in IDLE is dropped.
  assign done_c = ((state == ST_ISSUE) | (state == ST_WAIT)) & bus.mem_done;

  assign bus.mem_en    = mem_en;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.addr_sel  = addr_sel;
  assign bus.if_valid  = done_c & (addr_sel == OWNER_IF);
  assign bus.dm_valid  = done_c & (addr_sel == OWNER_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.if_stall  = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_valid;

endmodule
